// File: rtl/id_ex_hazard_reg_pkg.sv
// Shared pipeline definitions: control-bundle bit positions, MIPS opcodes
// and small field-decode helpers used by the ID/EX register and hazard logic.
package pipe_pkg;

  localparam int CTRL_W = 8;

  localparam int CTRL_REGWRITE = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_MEMREAD  = 5;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_ALUSRC   = 3;
  localparam int CTRL_REGDST   = 2;
  localparam int CTRL_ALUOP_HI = 1;
  localparam int CTRL_ALUOP_LO = 0;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL1 = 2'd1,
    ST_STALL2 = 2'd2
  } stall_state_t;

  // R-type writes rd, everything else that writes a register writes rt.
  function automatic logic [4:0] dest_of(input logic [5:0] op,
                                         input logic [4:0] rt,
                                         input logic [4:0] rd);
    return (op == OP_RTYPE) ? rd : rt;
  endfunction

  function automatic logic uses_rt_of(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

  function automatic logic is_branch_of(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/id_ex_hazard_reg_if.sv
// ID-side inputs, EX-side registered outputs and pipeline control of the
// ID/EX register bundled as one interface.
interface id_ex_hazard_reg_if #(
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter int CNT_W  = 16
);

  logic [31:0]       id_instru;
  logic [31:0]       id_pc4;
  logic [31:0]       id_rdata1;
  logic [31:0]       id_rdata2;
  logic [31:0]       id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              id_branch_taken;
  logic [31:0]       ex_mem_instru;
  logic              ex_mem_MemRead;

  logic [31:0]       ex_instru;
  logic [31:0]       ex_pc4;
  logic [31:0]       ex_rdata1;
  logic [31:0]       ex_rdata2;
  logic [31:0]       ex_imm;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              c_pc_write;
  logic              c_if_id_write;
  logic              c_if_id_flush;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  pipe_pkg::stall_state_t dbg_state;

  modport master (
    output id_instru, id_pc4, id_rdata1, id_rdata2, id_imm, id_ctrl,
           id_branch_taken, ex_mem_instru, ex_mem_MemRead,
    input  ex_instru, ex_pc4, ex_rdata1, ex_rdata2, ex_imm, ex_ctrl,
           c_pc_write, c_if_id_write, c_if_id_flush, stall_cnt, flush_cnt,
           dbg_state
  );

  modport slave (
    input  id_instru, id_pc4, id_rdata1, id_rdata2, id_imm, id_ctrl,
           id_branch_taken, ex_mem_instru, ex_mem_MemRead,
    output ex_instru, ex_pc4, ex_rdata1, ex_rdata2, ex_imm, ex_ctrl,
           c_pc_write, c_if_id_write, c_if_id_flush, stall_cnt, flush_cnt,
           dbg_state
  );

endinterface

// File: rtl/id_ex_hazard_reg_hazard_detect.sv
// Combinational hazard detection: load-use, branch-after-ALU and
// branch-after-load-in-MEM. Register $0 never creates a dependency.
module hazard_detect
  import pipe_pkg::*;
#(
  parameter int CTRL_W = pipe_pkg::CTRL_W
) (
  input  logic [31:0]       id_instru,
  input  logic [31:0]       ex_instru,
  input  logic [CTRL_W-1:0] ex_ctrl,
  input  logic [31:0]       ex_mem_instru,
  input  logic              ex_mem_MemRead,
  output logic              stall,
  output logic              branch_load_hazard
);

  logic [5:0] id_op;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic [4:0] ex_dest;
  logic [4:0] mem_dest;
  logic       uses_rt;
  logic       is_branch;
  logic       ex_hits_rs;
  logic       ex_hits_rt;
  logic       mem_hits;
  logic       load_use;
  logic       branch_alu;
  logic       unused_fields;

  assign id_op = id_instru[31:26];
  assign id_rs = id_instru[25:21];
  assign id_rt = id_instru[20:16];

  assign ex_dest  = dest_of(ex_instru[31:26], ex_instru[20:16], ex_instru[15:11]);
  assign mem_dest = dest_of(ex_mem_instru[31:26], ex_mem_instru[20:16],
                            ex_mem_instru[15:11]);

  assign uses_rt   = uses_rt_of(id_op);
  assign is_branch = is_branch_of(id_op);

  always_comb begin
    ex_hits_rs         = 1'b0;
    ex_hits_rt         = 1'b0;
    mem_hits           = 1'b0;
    load_use           = 1'b0;
    branch_alu         = 1'b0;
    branch_load_hazard = 1'b0;

    if (ex_dest != 5'd0) begin
      ex_hits_rs = (ex_dest == id_rs);
      ex_hits_rt = (ex_dest == id_rt);
    end
    if (mem_dest != 5'd0) begin
      mem_hits = (mem_dest == id_rs) || (mem_dest == id_rt);
    end

    // Only a loaded value forces a stall for ordinary consumers; branches
    // resolve in ID so they also wait on any ALU result still in EX.
    load_use           = ex_ctrl[CTRL_MEMREAD] && (ex_hits_rs || (uses_rt && ex_hits_rt));
    branch_alu         = is_branch && ex_ctrl[CTRL_REGWRITE] && (ex_hits_rs || ex_hits_rt);
    branch_load_hazard = is_branch && ex_mem_MemRead && mem_hits;
  end

  assign stall = load_use || branch_alu || branch_load_hazard;

  assign unused_fields = ^{id_instru[15:0], ex_instru[25:21], ex_instru[10:0],
                           ex_mem_instru[25:21], ex_mem_instru[10:0], ex_ctrl};

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with hazard stall, bubble injection, IF/ID flush
// gating and saturating stall/flush counters.
module id_ex_hazard_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  id_ex_hazard_reg_if.slave bus
);

  // Handshake: there is no valid/ready pair; the ID stage presents an
  // instruction every cycle and this block answers with c_pc_write /
  // c_if_id_write. When they are low the same ID contents must be held and
  // are re-presented, while a bubble is written into EX on that edge.

  logic              stall_raw;
  logic              branch_load_hazard;
  logic              stall;
  logic              flush;
  logic              prev_stall_q;
  stall_state_t      state;

  logic [31:0]       ex_instru_q;
  logic [31:0]       ex_pc4_q;
  logic [31:0]       ex_rdata1_q;
  logic [31:0]       ex_rdata2_q;
  logic [31:0]       ex_imm_q;
  logic [CTRL_W-1:0] ex_ctrl_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;

  hazard_detect #(
    .CTRL_W (CTRL_W)
  ) u_hazard_detect (
    .id_instru          (bus.id_instru),
    .ex_instru          (ex_instru_q),
    .ex_ctrl            (ex_ctrl_q),
    .ex_mem_instru      (bus.ex_mem_instru),
    .ex_mem_MemRead     (bus.ex_mem_MemRead),
    .stall              (stall_raw),
    .branch_load_hazard (branch_load_hazard)
  );

  // Reset forces the pipeline to run so fetch restarts cleanly.
  assign stall = stall_raw & ~rst;
  assign flush = bus.id_branch_taken & ~stall & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_instru_q <= NOP_INSTR;
      ex_pc4_q    <= '0;
      ex_rdata1_q <= '0;
      ex_rdata2_q <= '0;
      ex_imm_q    <= '0;
      ex_ctrl_q   <= '0;
    end else if (stall) begin
      ex_instru_q <= NOP_INSTR;
      ex_pc4_q    <= '0;
      ex_rdata1_q <= '0;
      ex_rdata2_q <= '0;
      ex_imm_q    <= '0;
      ex_ctrl_q   <= '0;
    end else begin
      ex_instru_q <= bus.id_instru;
      ex_pc4_q    <= bus.id_pc4;
      ex_rdata1_q <= bus.id_rdata1;
      ex_rdata2_q <= bus.id_rdata2;
      ex_imm_q    <= bus.id_imm;
      ex_ctrl_q   <= bus.id_ctrl;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_stall_q <= 1'b0;
    end else begin
      prev_stall_q <= stall;
    end
  end

  always_comb begin
    state = ST_RUN;
    if (stall) begin
      state = prev_stall_q ? ST_STALL2 : ST_STALL1;
    end
  end

  assign bus.ex_instru     = ex_instru_q;
  assign bus.ex_pc4        = ex_pc4_q;
  assign bus.ex_rdata1     = ex_rdata1_q;
  assign bus.ex_rdata2     = ex_rdata2_q;
  assign bus.ex_imm        = ex_imm_q;
  assign bus.ex_ctrl       = ex_ctrl_q;
  assign bus.c_pc_write    = ~stall;
  assign bus.c_if_id_write = ~stall;
  assign bus.c_if_id_flush = flush;
  assign bus.stall_cnt     = stall_cnt_q;
  assign bus.flush_cnt     = flush_cnt_q;
  assign bus.dbg_state     = state;

  // A second consecutive stall can only come from a load sitting in MEM,
  // because the first stall already put a bubble into EX.
  a_stall2_needs_mem_load: assert property (
    @(posedge clk) disable iff (rst) (state == ST_STALL2) |-> branch_load_hazard
  );

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Bench for the ID/EX hazard register: scenario tasks drive the ID stage and
// compare EX outputs against a queue of expected register contents.
module tb_id_ex_hazard_reg;
  import pipe_pkg::*;

  localparam int W = 168;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  id_ex_hazard_reg_if #(.CTRL_W(8), .CNT_W(16)) bus ();
  id_ex_hazard_reg_if #(.CTRL_W(8), .CNT_W(2))  bus2 ();

  id_ex_hazard_reg #(.CTRL_W(8), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  id_ex_hazard_reg #(.CTRL_W(8), .CNT_W(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  localparam logic [7:0] C_R   = 8'h86;
  localparam logic [7:0] C_LW  = 8'hE8;
  localparam logic [7:0] C_SW  = 8'h18;
  localparam logic [7:0] C_BR  = 8'h01;
  localparam logic [7:0] C_IMM = 8'h88;

  function automatic logic [31:0] r_type(input int rs, input int rt, input int rd);
    return {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] i_type(input int op, input int rs, input int rt, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  task automatic idle_inputs();
    bus.id_instru = '0;  bus.id_pc4 = '0;  bus.id_rdata1 = '0;
    bus.id_rdata2 = '0;  bus.id_imm = '0;  bus.id_ctrl = '0;
    bus.id_branch_taken = 1'b0;  bus.ex_mem_instru = '0;  bus.ex_mem_MemRead = 1'b0;
    bus2.id_instru = '0; bus2.id_pc4 = '0; bus2.id_rdata1 = '0;
    bus2.id_rdata2 = '0; bus2.id_imm = '0; bus2.id_ctrl = '0;
    bus2.id_branch_taken = 1'b0; bus2.ex_mem_instru = '0; bus2.ex_mem_MemRead = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  // One ID cycle: drive, check pipeline control before the edge, push the
  // expected EX contents, then pop and compare them after the edge.
  task automatic step(input logic [31:0] instr, input logic [7:0] ctrl,
                      input logic taken, input logic [31:0] mem_instr,
                      input logic mem_rd, input logic exp_stall,
                      input logic exp_flush, input stall_state_t exp_state,
                      input string tag);
    logic [W-1:0] exp_v;
    logic [W-1:0] got_v;
    @(negedge clk);
    bus.id_instru       = instr;
    bus.id_pc4          = $urandom;
    bus.id_rdata1       = $urandom;
    bus.id_rdata2       = $urandom;
    bus.id_imm          = $urandom_range(0, 65535);
    bus.id_ctrl         = ctrl;
    bus.id_branch_taken = taken;
    bus.ex_mem_instru   = mem_instr;
    bus.ex_mem_MemRead  = mem_rd;
    #1;
    checks++;
    if (bus.c_pc_write !== !exp_stall || bus.c_if_id_write !== !exp_stall) begin
      errors++;
      $display("FAIL %s pc_write/if_id_write got %b/%b want %b", tag,
               bus.c_pc_write, bus.c_if_id_write, !exp_stall);
    end
    checks++;
    if (bus.c_if_id_flush !== exp_flush) begin
      errors++;
      $display("FAIL %s flush got %b want %b", tag, bus.c_if_id_flush, exp_flush);
    end
    checks++;
    if (bus.dbg_state !== exp_state) begin
      errors++;
      $display("FAIL %s state got %0d want %0d", tag, bus.dbg_state, exp_state);
    end
    exp_q.push_back(exp_stall ? {W{1'b0}}
                              : {instr, bus.id_pc4, bus.id_rdata1, bus.id_rdata2,
                                 bus.id_imm, ctrl});
    @(posedge clk);
    #1;
    got_v = {bus.ex_instru, bus.ex_pc4, bus.ex_rdata1, bus.ex_rdata2, bus.ex_imm, bus.ex_ctrl};
    exp_v = exp_q.pop_front();
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s ex_regs got %h want %h", tag, got_v, exp_v);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    bus.id_instru       = i_type(4, 2, 5, 0);
    bus.id_branch_taken = 1'b1;
    bus.ex_mem_instru   = i_type(35, 1, 2, 0);
    bus.ex_mem_MemRead  = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.ex_instru, bus.ex_pc4, bus.ex_rdata1, bus.ex_rdata2, bus.ex_imm, bus.ex_ctrl} !== {W{1'b0}}) begin
      errors++;
      $display("FAIL reset_regs got nonzero ex_instru=%h ex_ctrl=%h want 0", bus.ex_instru, bus.ex_ctrl);
    end
    checks++;
    if (bus.c_pc_write !== 1'b1 || bus.c_if_id_write !== 1'b1 || bus.c_if_id_flush !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got pc=%b ifid=%b flush=%b want 1 1 0",
               bus.c_pc_write, bus.c_if_id_write, bus.c_if_id_flush);
    end
    checks++;
    if (bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd0 || bus.dbg_state !== ST_RUN) begin
      errors++;
      $display("FAIL reset_cnt got stall=%0d flush=%0d state=%0d want 0 0 0",
               bus.stall_cnt, bus.flush_cnt, bus.dbg_state);
    end
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    step(i_type(35, 1, 2, 0), C_LW, 1'b0, '0, 1'b0, 1'b0, 1'b0, ST_RUN, "lu_lw");
    step(r_type(2, 4, 3), C_R, 1'b0, '0, 1'b0, 1'b1, 1'b0, ST_STALL1, "lu_stall");
    step(r_type(2, 4, 3), C_R, 1'b0, '0, 1'b0, 1'b0, 1'b0, ST_RUN, "lu_go");
    checks++;
    if (bus.stall_cnt !== 16'd1) begin
      errors++;
      $display("FAIL lu_stall_cnt got %0d want 1", bus.stall_cnt);
    end
  endtask

  task automatic test_lw_branch();
    do_reset();
    step(i_type(35, 1, 2, 0), C_LW, 1'b0, '0, 1'b0, 1'b0, 1'b0, ST_RUN, "lb_lw");
    step(i_type(4, 2, 5, 3), C_BR, 1'b0, '0, 1'b0, 1'b1, 1'b0, ST_STALL1, "lb_s1");
    step(i_type(4, 2, 5, 3), C_BR, 1'b0, i_type(35, 1, 2, 0), 1'b1, 1'b1, 1'b0, ST_STALL2, "lb_s2");
    step(i_type(4, 2, 5, 3), C_BR, 1'b0, '0, 1'b0, 1'b0, 1'b0, ST_RUN, "lb_go");
    checks++;
    if (bus.stall_cnt !== 16'd2) begin
      errors++;
      $display("FAIL lb_stall_cnt got %0d want 2", bus.stall_cnt);
    end
  endtask

  task automatic test_alu_branch_flush();
    do_reset();
    step(r_type(3, 4, 2), C_R, 1'b0, '0, 1'b0, 1'b0, 1'b0, ST_RUN, "ab_add");
    step(i_type(4, 2, 0, 8), C_BR, 1'b1, '0, 1'b0, 1'b1, 1'b0, ST_STALL1, "ab_stall");
    step(i_type(4, 2, 0, 8), C_BR, 1'b1, '0, 1'b0, 1'b0, 1'b1, ST_RUN, "ab_flush");
    checks++;
    if (bus.flush_cnt !== 16'd1 || bus.stall_cnt !== 16'd1) begin
      errors++;
      $display("FAIL ab_counts got flush=%0d stall=%0d want 1 1", bus.flush_cnt, bus.stall_cnt);
    end
  endtask

  task automatic test_uses_rt();
    do_reset();
    step(i_type(35, 1, 0, 0), C_LW, 1'b0, '0, 1'b0, 1'b0, 1'b0, ST_RUN, "ur_lw0");
    step(r_type(0, 0, 3), C_R, 1'b0, '0, 1'b0, 1'b0, 1'b0, ST_RUN, "ur_reg0");
    step(i_type(35, 1, 2, 0), C_LW, 1'b0, '0, 1'b0, 1'b0, 1'b0, ST_RUN, "ur_lw2");
    step(i_type(43, 1, 2, 4), C_SW, 1'b0, '0, 1'b0, 1'b1, 1'b0, ST_STALL1, "ur_sw_stall");
    step(i_type(43, 1, 2, 4), C_SW, 1'b0, '0, 1'b0, 1'b0, 1'b0, ST_RUN, "ur_sw_go");
    step(i_type(35, 1, 7, 0), C_LW, 1'b0, '0, 1'b0, 1'b0, 1'b0, ST_RUN, "ur_lw7");
    step(i_type(8, 2, 5, 1), C_IMM, 1'b0, '0, 1'b0, 1'b0, 1'b0, ST_RUN, "ur_addi_indep");
    step(i_type(35, 1, 7, 0), C_LW, 1'b0, '0, 1'b0, 1'b0, 1'b0, ST_RUN, "ur_lw7b");
    step(i_type(8, 2, 7, 1), C_IMM, 1'b0, '0, 1'b0, 1'b0, 1'b0, ST_RUN, "ur_addi_rt");
    checks++;
    if (bus.stall_cnt !== 16'd1) begin
      errors++;
      $display("FAIL ur_stall_cnt got %0d want 1", bus.stall_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(r_type(3 * i + 1, 3 * i + 2, 3 * i + 3), C_R, 1'b0, '0, 1'b0,
           1'b0, 1'b0, ST_RUN, "b2b");
    end
    checks++;
    if (bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL b2b_counts got stall=%0d flush=%0d want 0 0", bus.stall_cnt, bus.flush_cnt);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    step(i_type(35, 1, 2, 0), C_LW, 1'b0, '0, 1'b0, 1'b0, 1'b0, ST_RUN, "rm_lw");
    step(r_type(2, 4, 3), C_R, 1'b0, '0, 1'b0, 1'b1, 1'b0, ST_STALL1, "rm_stall");
    step(r_type(2, 4, 3), C_R, 1'b0, '0, 1'b0, 1'b0, 1'b0, ST_RUN, "rm_go");
    step(i_type(35, 1, 2, 0), C_LW, 1'b0, '0, 1'b0, 1'b0, 1'b0, ST_RUN, "rm_lw2");
    @(negedge clk);
    bus.id_instru = r_type(2, 4, 3);
    bus.id_ctrl   = C_R;
    #1;
    checks++;
    if (bus.c_pc_write !== 1'b0 || bus.stall_cnt !== 16'd1 || bus.ex_instru !== i_type(35, 1, 2, 0)) begin
      errors++;
      $display("FAIL rm_pre got pc=%b cnt=%0d ex_instru=%h want 0 1 %h",
               bus.c_pc_write, bus.stall_cnt, bus.ex_instru, i_type(35, 1, 2, 0));
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.ex_instru !== 32'd0 || bus.ex_ctrl !== 8'd0 || bus.ex_pc4 !== 32'd0 || bus.c_pc_write !== 1'b1) begin
      errors++;
      $display("FAIL rm_async got ex_instru=%h ex_ctrl=%h pc=%b want 0 0 1",
               bus.ex_instru, bus.ex_ctrl, bus.c_pc_write);
    end
    checks++;
    if (bus.stall_cnt !== 16'd0 || bus.dbg_state !== ST_RUN) begin
      errors++;
      $display("FAIL rm_cnt got stall=%0d state=%0d want 0 0", bus.stall_cnt, bus.dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_counter_saturation();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus2.id_instru      = i_type(4, 2, 5, 0);
      bus2.id_ctrl        = C_BR;
      bus2.ex_mem_instru  = i_type(35, 1, 2, 0);
      bus2.ex_mem_MemRead = 1'b1;
      #1;
      if (i == 1) begin
        checks++;
        if (bus2.dbg_state !== ST_STALL2 || bus2.stall_cnt !== 2'd1) begin
          errors++;
          $display("FAIL sat_mid got state=%0d cnt=%0d want 2 1", bus2.dbg_state, bus2.stall_cnt);
        end
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus2.stall_cnt !== 2'd3) begin
      errors++;
      $display("FAIL sat_cnt got %0d want 3", bus2.stall_cnt);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_load_use();
    test_lw_branch();
    test_alu_branch_flush();
    test_uses_rt();
    test_back_to_back();
    test_reset_mid_stall();
    test_counter_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_hazard_reg.md
Name: id_ex_hazard_reg

Overview:
ID/EX pipeline register with integrated hazard detection for the 5-stage MIPS pipeline. It latches decoded instruction, operands and control from ID, and produces the ex_instru/control that the EX-stage forwarding unit consumes. It detects load-use and ID-branch hazards, holds PC and IF/ID, and injects bubbles into EX. It also gates IF/ID flush on taken branches and keeps saturating stall/flush performance counters.

Parameters:
CTRL_W, 8, control bundle width: [7]RegWrite [6]MemtoReg [5]MemRead [4]MemWrite [3]ALUSrc [2]RegDst [1:0]ALUOp
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
id_instru  in  32  IF/ID instruction being decoded
id_pc4  in  32  PC+4 of ID instruction
id_rdata1  in  32  register file read data, rs
id_rdata2  in  32  register file read data, rt
id_imm  in  32  sign-extended immediate
id_ctrl  in  CTRL_W  control from main decoder
id_branch_taken  in  1  ID-stage beq/bne comparison resolved taken
ex_mem_instru  in  32  EX/MEM instruction
ex_mem_MemRead  in  1  EX/MEM MemRead
ex_instru  out  32  ID/EX instruction (feeds forwarding unit)
ex_pc4, ex_rdata1, ex_rdata2, ex_imm  out  32 each  registered copies
ex_ctrl  out  CTRL_W  registered control
c_pc_write  out  1  PC enable (0 = hold)
c_if_id_write  out  1  IF/ID enable (0 = hold)
c_if_id_flush  out  1  zero IF/ID on next edge
stall_cnt  out  CNT_W  stall cycles since reset
flush_cnt  out  CNT_W  flushes since reset

Behaviour:
- Reset (async, immediate): ex_instru, ex_pc4, ex_rdata*, ex_imm, ex_ctrl = 0 (nop); stall_cnt = flush_cnt = 0. c_pc_write = c_if_id_write = 1 and c_if_id_flush = 0 during reset.
- Field decode: id_rs = id_instru[25:21]; id_rt = id_instru[20:16].
- Destination decode: ex_dest = ex_instru[15:11] if opcode == 0, else ex_instru[20:16]. mem_dest is decoded from ex_mem_instru the same way.
- uses_rt: opcode 0, 4 (beq), 5 (bne), 43 (sw). is_branch: opcode 4 or 5.
- Register 0 never causes a hazard.
- Stall (combinational) when any of the following holds:
  a) load-use: ex_ctrl[5] and ex_dest != 0 and (ex_dest == id_rs, or uses_rt and ex_dest == id_rt)
  b) branch after ALU op: is_branch and ex_ctrl[7] and ex_dest != 0 and ex_dest matches id_rs or id_rt
  c) branch after load in MEM: is_branch and ex_mem_MemRead and mem_dest != 0 and mem_dest matches id_rs or id_rt
- lw immediately followed by beq on the same register therefore stalls 2 cycles: a/b in cycle 1, then c in cycle 2.
- On stall: c_pc_write = 0, c_if_id_write = 0. Next edge loads a bubble: ex_ctrl = 0 and ex_instru = 0; the other data registers are don't-care but are zeroed.
- No stall: every ex_* register loads its id_* counterpart on the edge; latency is 1 cycle.
- c_if_id_flush = id_branch_taken & ~stall. Stall dominates: the branch re-evaluates after the stall clears. ID/EX is never flushed by a branch.
- stall_cnt increments on every edge where stall = 1; flush_cnt increments on every edge where c_if_id_flush = 1. Both saturate at all-ones (no wrap).
- Internal state view for verification: RUN when no stall, STALL1 on a first stall cycle, STALL2 on a consecutive stall cycle. The state is derived from a registered previous-stall bit. STALL2 without a rule-c hazard is illegal; flag it with an assertion.
- Reset mid-stall: the bubble is discarded, the state returns to RUN, and counters clear.

Decomposition:
- Shared package pipe_pkg holds: control bit index constants (CTRL_REGWRITE=7 … CTRL_ALUOP=1:0), opcode constants (OP_RTYPE=0, OP_BEQ=4, OP_BNE=5, OP_LW=35, OP_SW=43), CTRL_W, and a NOP_INSTR=32'h0 constant.
- One sub-module, hazard_detect: purely combinational. It takes id_instru, ex_instru, ex_ctrl, ex_mem_instru and ex_mem_MemRead, and outputs stall.
- The top level holds the registers, counters and state.

Test Plan:
- lw $2,0($1) in EX, add $3,$2,$4 in ID → 1 stall: c_pc_write = 0, next ex_ctrl = 0, ex_instru = 0; add enters EX the cycle after; stall_cnt = 1.
- lw $2 in EX, beq $2,$5 in ID → stall in 2 consecutive cycles (states STALL1, STALL2); beq proceeds on the 3rd; stall_cnt = 2.
- add $2,$3,$4 in EX, beq $2,$0 in ID with id_branch_taken = 1 → 1 stall with c_if_id_flush = 0; next cycle no stall and c_if_id_flush = 1; flush_cnt = 1.
- lw $0,0($1) in EX, add $3,$0,$0 in ID → no stall; sw $2 in ID after lw $2 → stall (uses_rt); addi $5,$2,1 after lw $7 → no stall.
- Stream of 4 independent R-type ops → ex_* equal prior-cycle id_* each cycle, no stalls, counters stay 0.
- Assert rst during a stall → outputs zero immediately, c_pc_write = 1, counters = 0; with CNT_W = 2 forced, 5 stalls give stall_cnt = 3.
